// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - drains {last,data} fifo entries into a valid/ready beat stream with IFG and truncation; `define STATS_EN adds frame_count/drop_count
module fifo_frame_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int IFG_CYCLES = 12,
   parameter int MAX_BEATS  = 1522
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  fifo_read_enable,
   input  logic [DATA_WIDTH:0]   fifo_read_data,
   input  logic                  fifo_is_empty,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   input  logic                  tx_ready,
   output logic                  truncated,
`ifdef STATS_EN
   output logic [31:0]           frame_count,
   output logic [15:0]           drop_count,
`endif
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, STREAM, DROP, GAP} state_t;

   localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);
   localparam logic [7:0]  GAP_LAST  = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   state_t              frame_done_state;
   logic [DATA_WIDTH:0] entry_q [2];
   logic [1:0]          occ;
   logic [1:0]          next_occ;
   logic                in_flight;
   logic [15:0]         beat_cnt;
   logic [7:0]          gap_cnt;
   logic                trunc_q;
   logic                head_last;
   logic                at_max;
   logic                accept;
   logic                cut_beat;
   logic                drop_pop;
   logic                pop;
   logic                push;

   // Handshake, pop and prefetch decisions; read is issued against the post-pop occupancy so one beat per cycle is sustained
   always_comb begin
      head_last        = entry_q[0][DATA_WIDTH];
      at_max           = (beat_cnt == LAST_BEAT);
      tx_valid         = (state == STREAM) && (occ != 2'd0);
      tx_last          = tx_valid && (head_last || at_max);
      tx_data          = entry_q[0][DATA_WIDTH-1:0];
      accept           = tx_valid && tx_ready;
      cut_beat         = accept && at_max && !head_last;
      drop_pop         = (state == DROP) && (occ != 2'd0);
      pop              = accept || drop_pop;
      push             = in_flight;
      next_occ         = occ + {1'b0, push} - {1'b0, pop};
      fifo_read_enable = reset && !fifo_is_empty && (next_occ < 2'd2);
      busy             = (state != IDLE) || (occ != 2'd0);
      truncated        = trunc_q;
   end

   // Next-state logic; a frame end either opens the gap or, with no gap, resumes straight away
   always_comb begin
      state_nxt        = state;
      frame_done_state = (next_occ != 2'd0) ? STREAM : IDLE;
      if (IFG_CYCLES != 0) begin
         frame_done_state = GAP;
      end
      case (state)
         IDLE: begin
            if (next_occ != 2'd0) state_nxt = STREAM;
         end
         STREAM: begin
            if (cut_beat)                   state_nxt = DROP;
            else if (accept && head_last)   state_nxt = frame_done_state;
         end
         DROP: begin
            if (drop_pop && head_last)      state_nxt = frame_done_state;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)        state_nxt = (next_occ != 2'd0) ? STREAM : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, read tracking, beat and gap counters
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         in_flight <= 1'b0;
         beat_cnt  <= 16'd0;
         gap_cnt   <= 8'd0;
         trunc_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_flight <= fifo_read_enable;
         trunc_q   <= cut_beat;
         if ((state != STREAM) || (accept && tx_last)) begin
            beat_cnt <= 16'd0;
         end else if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      end
   end

   // Two-entry output buffer, head in slot 0; simultaneous push and pop keeps occupancy and order
   always_ff @(posedge clock) begin
      if (!reset) begin
         occ        <= 2'd0;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         occ <= next_occ;
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) entry_q[0] <= fifo_read_data;
               else             entry_q[1] <= fifo_read_data;
            end
            2'b01: begin
               entry_q[0] <= entry_q[1];
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  entry_q[0] <= fifo_read_data;
               end else begin
                  entry_q[0] <= entry_q[1];
                  entry_q[1] <= fifo_read_data;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef STATS_EN
   // Frame and discard statistics, wrapping naturally
   always_ff @(posedge clock) begin
      if (!reset) begin
         frame_count <= 32'd0;
         drop_count  <= 16'd0;
      end else begin
         if (accept && tx_last) frame_count <= frame_count + 32'd1;
         if (drop_pop)          drop_count  <= drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb/tb_fifo_frame_reader.sv - randomized self-checking bench for fifo_frame_reader with a behavioural fifo and frame model
`timescale 1ns/1ps
module tb_fifo_frame_reader;
   localparam int DW    = 8;
   localparam int IFG   = 2;
   localparam int MAXB  = 4;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          fifo_read_enable;
   logic [DW:0]   fifo_read_data;
   logic          fifo_is_empty;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_last;
   logic          tx_ready = 1'b1;
   logic          truncated;
   logic          busy;
`ifdef STATS_EN
   logic [31:0]   frame_count;
   logic [15:0]   drop_count;
`endif

   fifo_frame_reader #(.DATA_WIDTH(DW), .IFG_CYCLES(IFG), .MAX_BEATS(MAXB)) dut (
      .clock(clock), .reset(reset),
      .fifo_read_enable(fifo_read_enable), .fifo_read_data(fifo_read_data), .fifo_is_empty(fifo_is_empty),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
      .truncated(truncated),
`ifdef STATS_EN
      .frame_count(frame_count), .drop_count(drop_count),
`endif
      .busy(busy)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic        wr_en = 1'b0;
   logic [DW:0] wr_data = '0;
   logic [DW:0] fmem [DEPTH];
   int          fcount = 0, frd = 0, fwr = 0, fifo_err = 0;
   logic [DW:0] push_q [$];
   logic [DW:0] exp_q [$];
   logic [DW:0] got_q [$];
   int          gap_q [$];
   int          acc_cnt = 0, trunc_cnt = 0, stab_err = 0, rd_empty_err = 0;
   bit          in_gap = 0, busy_track = 0, stall_pending = 0;
   int          gap_len = 0, busy_run = 0, last_busy_run = -1;
   logic [DW-1:0] stall_data = '0;
   logic        stall_last = 1'b0;
   int          ready_mode = 0;
   logic        ready_hold = 1'b1;
   int          exp_frames = 0, exp_drops = 0, exp_trunc = 0;

   // Synchronous fifo model: read data appears the cycle after the read enable
   always @(posedge clock) begin
      if (!reset) begin
         fcount <= 0; frd <= 0; fwr <= 0; fifo_read_data <= '0;
      end else begin
         if (fifo_read_enable) begin
            fifo_read_data <= fmem[frd];
            frd <= (frd + 1) % DEPTH;
         end
         if (wr_en) begin
            fmem[fwr] <= wr_data;
            fwr <= (fwr + 1) % DEPTH;
         end
         if ((fifo_read_enable && fcount == 0) || (wr_en && fcount == DEPTH && !fifo_read_enable))
            fifo_err <= fifo_err + 1;
         fcount <= fcount + (wr_en ? 1 : 0) - (fifo_read_enable ? 1 : 0);
      end
   end
   assign fifo_is_empty = (fcount == 0);

   // Stream monitor sampled mid-cycle
   always @(negedge clock) begin
      if (!reset) begin
         stall_pending = 0; in_gap = 0; busy_track = 0;
      end else begin
         if (stall_pending && (!tx_valid || tx_data !== stall_data || tx_last !== stall_last)) stab_err++;
         stall_pending = tx_valid && !tx_ready;
         stall_data = tx_data; stall_last = tx_last;
         if (fifo_read_enable && fifo_is_empty) rd_empty_err++;
         if (truncated) trunc_cnt++;
         if (in_gap) begin
            if (tx_valid) begin gap_q.push_back(gap_len); in_gap = 0; end
            else gap_len++;
         end
         if (busy_track) begin
            if (tx_valid) busy_track = 0;
            else if (busy) busy_run++;
            else begin last_busy_run = busy_run; busy_track = 0; end
         end
         if (tx_valid && tx_ready) begin
            got_q.push_back({tx_last, tx_data});
            acc_cnt++;
            if (tx_last) begin in_gap = 1; gap_len = 0; busy_track = 1; busy_run = 0; end
         end
      end
   end

   // Sink ready driver
   initial begin
      forever begin
         @(posedge clock); #1;
         tx_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : ready_hold;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference model: builds fifo entries and the expected emitted beats for one frame
   task automatic add_frame(input logic [7:0] first, input logic [7:0] step, input int len, input bit rnd);
      int kept;
      logic [7:0] d;
      kept = (len < MAXB) ? len : MAXB;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(first + 8'(i) * step);
         push_q.push_back({(i == len - 1), d});
         if (i < kept) exp_q.push_back({(i == kept - 1), d});
      end
      exp_frames++;
      if (len > MAXB) begin exp_trunc++; exp_drops += len - MAXB; end
   endtask

   task automatic push_all();
      int guard = 0;
      while (push_q.size() != 0 && guard < 5000) begin
         @(posedge clock); #1;
         guard++;
         if (fcount < DEPTH) begin wr_en = 1'b1; wr_data = push_q.pop_front(); end
         else wr_en = 1'b0;
      end
      @(posedge clock); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      int quiet = 0;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (push_q.size() == 0 && !wr_en && fifo_is_empty && !busy) quiet++;
         else quiet = 0;
         if (quiet >= 4) begin ok = 1; break; end
      end
      #1;
   endtask

   task automatic start_test();
      got_q.delete(); exp_q.delete(); gap_q.delete();
      in_gap = 0; trunc_cnt = 0; last_busy_run = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; ready_mode = 0; ready_hold = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if ({tx_valid, fifo_read_enable, truncated, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset cycle %0d valid/rd/trunc/busy got %b expected 0000", c,
                     {tx_valid, fifo_read_enable, truncated, busy});
         end
      end
      reset = 1'b1;
      exp_frames = 0; exp_drops = 0; exp_trunc = 0;
   endtask

   task automatic test_single_frame();
      int n;
      bit ok;
      start_test();
      add_frame(8'h11, 8'h11, 3, 0);
      fork push_all(); join_none
      n = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (!fifo_is_empty) begin n = 0; break; end
      end
      if (n == 0) begin
         while (!tx_valid && n < 20) begin @(negedge clock); n++; end
      end
      checks++;
      if (n != 2) begin errors++; $display("FAIL single first_beat_latency got %0d expected 2", n); end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
      checks++;
      if (last_busy_run != IFG) begin errors++; $display("FAIL single gap_cycles got %0d expected %0d", last_busy_run, IFG); end
   endtask

   task automatic test_stall();
      int base;
      bit ok;
      start_test();
      base = acc_cnt;
      add_frame(8'h11, 8'h11, 3, 0);
      fork push_all(); join_none
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock); #1;
         if (acc_cnt >= base + 1) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stall first_beat_timeout got 0 expected 1"); end
      ready_hold = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL stall hold cycle %0d got valid=%b data=%h expected valid=1 data=22", c, tx_valid, tx_data);
         end
      end
      ready_hold = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL stall stability_errors got %0d expected 0", stab_err); end
   endtask

   task automatic test_truncate();
      bit ok;
      start_test();
      add_frame(8'h01, 8'h01, 6, 0);
      fork push_all(); join_none
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL trunc drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL trunc beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL trunc beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
      checks++;
      if (trunc_cnt != 1) begin errors++; $display("FAIL trunc pulses got %0d expected 1", trunc_cnt); end
`ifdef STATS_EN
      checks++;
      if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL trunc drop_count got %0d expected %0d", drop_count, exp_drops); end
`endif
   endtask

   task automatic test_back_to_back();
      bit ok;
      start_test();
      add_frame(8'hA0, 8'h00, 1, 0);
      add_frame(8'hB0, 8'h01, 2, 0);
      fork push_all(); join_none
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
      checks++;
      if (gap_q.size() != 1 || gap_q[0] != IFG) begin
         errors++;
         $display("FAIL b2b idle_gap got %0d (n=%0d) expected %0d", (gap_q.size() != 0) ? gap_q[0] : -1, gap_q.size(), IFG);
      end
   endtask

   task automatic test_random();
      bit ok;
      start_test();
      for (int f = 0; f < 12; f++) add_frame(8'h00, 8'h00, $urandom_range(1, 6), 1);
      ready_mode = 1;
      fork push_all(); join_none
      wait_drain(ok);
      ready_mode = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL random drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
      for (int i = 0; i < gap_q.size(); i++) begin
         checks++;
         if (gap_q[i] < IFG) begin errors++; $display("FAIL random gap[%0d] got %0d expected >=%0d", i, gap_q[i], IFG); end
      end
      checks++;
      if (trunc_cnt != exp_trunc - 1) begin errors++; $display("FAIL random trunc_pulses got %0d expected %0d", trunc_cnt, exp_trunc - 1); end
      checks++;
      if (stab_err != 0 || fifo_err != 0 || rd_empty_err != 0) begin
         errors++;
         $display("FAIL random protocol stab=%0d fifo=%0d rd_empty=%0d expected all 0", stab_err, fifo_err, rd_empty_err);
      end
`ifdef STATS_EN
      checks++;
      if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL random frame_count got %0d expected %0d", frame_count, exp_frames); end
      checks++;
      if (drop_count !== 16'(exp_drops)) begin errors++; $display("FAIL random drop_count got %0d expected %0d", drop_count, exp_drops); end
`endif
   endtask

   task automatic test_reset_mid_frame();
      int base;
      bit ok;
      start_test();
      ready_hold = 1'b0;
      base = acc_cnt;
      add_frame(8'h61, 8'h01, 4, 0);
      push_all();
      ready_hold = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock); #1;
         if (acc_cnt >= base + 2) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL midreset two_beats_timeout got 0 expected 1"); end
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if ({tx_valid, tx_last, fifo_read_enable, truncated, busy} !== 5'b0 || tx_data !== '0) begin
         errors++;
         $display("FAIL midreset outputs got valid/last/rd/trunc/busy=%b data=%h expected 0", 
                  {tx_valid, tx_last, fifo_read_enable, truncated, busy}, tx_data);
      end
`ifdef STATS_EN
      checks++;
      if (frame_count !== 32'd0 || drop_count !== 16'd0) begin
         errors++;
         $display("FAIL midreset stats got %0d/%0d expected 0/0", frame_count, drop_count);
      end
`endif
      reset = 1'b1;
      start_test();
      exp_frames = 0; exp_drops = 0; exp_trunc = 0;
      add_frame(8'h71, 8'h01, 2, 0);
      fork push_all(); join_none
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midreset drain_timeout got 0 expected 1"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset beats got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset beat[%0d] got %h expected %h", i, got_q[i], exp_q[i]); break; end
      end
`ifdef STATS_EN
      checks++;
      if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL midreset frame_count got %0d expected %0d", frame_count, exp_frames); end
`endif
   endtask

   initial begin
      test_reset();
      repeat (2) @(negedge clock);
      test_single_frame();
      test_stall();
      test_truncate();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
